// File: rtl/qspi_arbiter.sv
// Arbiter sharing one QSPI engine between the ROM fetch port and the RAM data port.
// Runs one engine transaction at a time and keeps chip select high for a minimum gap between transactions.
module qspi_arbiter #(
   parameter int unsigned CS_GAP       = 2,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rom_req,
   input  logic [22:0] rom_addr,
   output logic [31:0] rom_data,
   output logic        rom_done,
   input  logic        ram_req,
   input  logic        ram_we,
   input  logic [23:0] ram_addr,
   input  logic [31:0] ram_wdata,
   output logic [31:0] ram_rdata,
   output logic        ram_done,
   output logic        eng_start,
   output logic        eng_write,
   output logic [23:0] eng_address,
   output logic [31:0] eng_data_in,
   input  logic [31:0] eng_data_out,
   input  logic        eng_busy,
   output logic        cs_sel,
   output logic        active,
   output logic        timeout_err
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ISSUE     = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_XFER      = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;
   localparam logic [2:0] ST_GAP       = 3'd5;

   localparam logic GRANT_ROM = 1'b0;
   localparam logic GRANT_RAM = 1'b1;

   // One counter serves both the busy timeout and the CS gap, so size it for the larger.
   localparam int unsigned CNT_MAX = (BUSY_TIMEOUT > CS_GAP) ? BUSY_TIMEOUT : CS_GAP;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);

   logic [2:0]       state_r;
   logic [2:0]       state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             grant_r;
   logic             grant_s;
   logic             last_grant_r;
   logic             timeout_s;
   logic             issue_s;
   logic             finish_s;

   logic             eng_start_r;
   logic             eng_write_r;
   logic [23:0]      eng_address_r;
   logic [31:0]      eng_data_in_r;
   logic             cs_sel_r;
   logic             active_r;
   logic             rom_done_r;
   logic             ram_done_r;
   logic [31:0]      rom_data_r;
   logic [31:0]      ram_rdata_r;
   logic             timeout_err_r;

   assign issue_s  = (state_r == ST_IDLE) && (state_s == ST_ISSUE);
   assign finish_s = ((state_r == ST_WAIT_BUSY) || (state_r == ST_XFER)) && (state_s == ST_DONE);

   // Next-state, grant and cycle-counter decisions
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      grant_s   = grant_r;
      timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_s = CNT_ZERO;
            if (rom_req && ram_req) begin
               grant_s = ~last_grant_r;
               state_s = ST_ISSUE;
            end else if (rom_req) begin
               grant_s = GRANT_ROM;
               state_s = ST_ISSUE;
            end else if (ram_req) begin
               grant_s = GRANT_RAM;
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_s   = CNT_ZERO;
            state_s = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (eng_busy) begin
               state_s = ST_XFER;
            end else if (cnt_r == BUSY_LAST) begin
               timeout_s = 1'b1;
               state_s   = ST_DONE;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_XFER: begin
            if (!eng_busy) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_XFER;
            end
         end
         ST_DONE: begin
            cnt_s   = CNT_ZERO;
            state_s = ST_GAP;
         end
         ST_GAP: begin
            if (cnt_r == GAP_LAST) begin
               cnt_s   = CNT_ZERO;
               state_s = ST_IDLE;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            cnt_s   = CNT_ZERO;
            state_s = ST_IDLE;
         end
      endcase
   end

   // Sequencer state, counter and grant history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= CNT_ZERO;
         grant_r      <= GRANT_ROM;
         last_grant_r <= GRANT_RAM;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         grant_r <= grant_s;
         if (state_r == ST_DONE) begin
            last_grant_r <= grant_r;
         end
      end
   end

   // Engine command fields are latched only at grant so they stay stable until the next grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_write_r   <= 1'b0;
         eng_address_r <= 24'h00_0000;
         eng_data_in_r <= 32'h0000_0000;
         cs_sel_r      <= 1'b0;
      end else if (issue_s) begin
         cs_sel_r <= grant_s;
         if (grant_s == GRANT_RAM) begin
            eng_write_r   <= ram_we;
            eng_address_r <= ram_addr;
            eng_data_in_r <= ram_wdata;
         end else begin
            eng_write_r   <= 1'b0;
            eng_address_r <= {1'b1, rom_addr};
            eng_data_in_r <= 32'h0000_0000;
         end
      end
   end

   // Start strobe, activity window and per-port completion pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_start_r <= 1'b0;
         active_r    <= 1'b0;
         rom_done_r  <= 1'b0;
         ram_done_r  <= 1'b0;
      end else begin
         eng_start_r <= issue_s;
         rom_done_r  <= finish_s && (grant_r == GRANT_ROM);
         ram_done_r  <= finish_s && (grant_r == GRANT_RAM);
         if (issue_s) begin
            active_r <= 1'b1;
         end else if (state_r == ST_DONE) begin
            active_r <= 1'b0;
         end
      end
   end

   // Result capture; an aborted transaction reports all-ones and latches the sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_data_r    <= 32'h0000_0000;
         ram_rdata_r   <= 32'h0000_0000;
         timeout_err_r <= 1'b0;
      end else if (finish_s) begin
         if (timeout_s) begin
            timeout_err_r <= 1'b1;
         end
         if (grant_r == GRANT_ROM) begin
            rom_data_r <= timeout_s ? 32'hFFFF_FFFF : eng_data_out;
         end else if (timeout_s) begin
            ram_rdata_r <= 32'hFFFF_FFFF;
         end else if (!eng_write_r) begin
            ram_rdata_r <= eng_data_out;
         end
      end
   end

   assign eng_start   = eng_start_r;
   assign eng_write   = eng_write_r;
   assign eng_address = eng_address_r;
   assign eng_data_in = eng_data_in_r;
   assign cs_sel      = cs_sel_r;
   assign active      = active_r;
   assign rom_done    = rom_done_r;
   assign ram_done    = ram_done_r;
   assign rom_data    = rom_data_r;
   assign ram_rdata   = ram_rdata_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Self-checking bench for qspi_arbiter: a behavioural QSPI engine/memory plus a
// port-level reference model of what each requester should see.
module tb_qspi_arbiter;
   localparam int CS_GAP       = 2;
   localparam int BUSY_TIMEOUT = 16;
   localparam int TXN_BUDGET   = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rom_req, ram_req, ram_we;
   logic [22:0] rom_addr;
   logic [23:0] ram_addr;
   logic [31:0] ram_wdata, rom_data, ram_rdata;
   logic        rom_done, ram_done;
   logic        eng_start, eng_write, eng_busy, cs_sel, active, timeout_err;
   logic [23:0] eng_address;
   logic [31:0] eng_data_in, eng_data_out;

   int          checks = 0;
   int          errors = 0;
   int          eng_len = 4;
   bit          eng_stuck = 1'b0;
   logic [31:0] ref_ram [0:31];
   logic [31:0] exp_rom_data, exp_ram_rdata;

   qspi_arbiter #(.CS_GAP(CS_GAP), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data), .rom_done(rom_done),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ram_done(ram_done),
      .eng_start(eng_start), .eng_write(eng_write), .eng_address(eng_address),
      .eng_data_in(eng_data_in), .eng_data_out(eng_data_out), .eng_busy(eng_busy),
      .cs_sel(cs_sel), .active(active), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Flash contents as seen through the engine (read-only)
   function automatic logic [31:0] rom_word(input logic [23:0] a);
      if (a == 24'h800100) return 32'hDEADBEEF;
      return {8'hC3, a ^ 24'h13579B};
   endfunction

   function automatic logic [31:0] ram_init(input int i);
      return 32'h5500_0000 | 32'(i);
   endfunction

   // Engine model: busy rises the cycle after start, stays high eng_len cycles, RAM indexed by addr[4:0]
   logic [31:0] eng_mem [0:31];
   logic        eng_cs_r, eng_we_r;
   logic [23:0] eng_addr_r;
   logic [31:0] eng_wd_r;
   int          eng_left;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_busy     <= 1'b0;
         eng_left     <= 0;
         eng_data_out <= 32'h0;
         eng_cs_r     <= 1'b0;
         eng_we_r     <= 1'b0;
         eng_addr_r   <= 24'h0;
         eng_wd_r     <= 32'h0;
         for (int i = 0; i < 32; i++) eng_mem[i] <= ram_init(i);
      end else if (eng_start === 1'b1 && !eng_stuck && !eng_busy) begin
         eng_busy   <= 1'b1;
         eng_left   <= eng_len - 1;
         eng_cs_r   <= cs_sel;
         eng_we_r   <= eng_write;
         eng_addr_r <= eng_address;
         eng_wd_r   <= eng_data_in;
      end else if (eng_busy) begin
         if (eng_left <= 0) begin
            eng_busy <= 1'b0;
            if (!eng_cs_r) eng_data_out <= rom_word(eng_addr_r);
            else if (eng_we_r) begin
               eng_mem[eng_addr_r[4:0]] <= eng_wd_r;
               eng_data_out <= 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
            end else eng_data_out <= eng_mem[eng_addr_r[4:0]];
         end else eng_left <= eng_left - 1;
      end
   end

   task automatic do_reset(input bit hold_both);
      rst_n   = 1'b0;
      rom_req = hold_both;
      ram_req = hold_both;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 32; i++) ref_ram[i] = ram_init(i);
      exp_rom_data  = 32'h0;
      exp_ram_rdata = 32'h0;
      rst_n = 1'b1;
   endtask

   // Drives one request from idle and records what the engine and requester saw
   task automatic run_txn(input bit port, input logic we, input logic [23:0] addr,
                          input logic [31:0] wdata,
                          output int lat_start, output int lat_done, output int n_start,
                          output int n_done, output logic [23:0] s_addr, output logic s_we,
                          output logic [31:0] s_din, output logic s_cs);
      lat_start = -1; lat_done = -1; n_start = 0; n_done = 0;
      s_addr = 24'h0; s_we = 1'b0; s_din = 32'h0; s_cs = 1'b0;
      repeat (CS_GAP + 2) @(negedge clk);
      if (port) begin
         ram_we = we; ram_addr = addr; ram_wdata = wdata; ram_req = 1'b1;
      end else begin
         rom_addr = addr[22:0]; rom_req = 1'b1;
      end
      for (int c = 1; c <= TXN_BUDGET; c++) begin
         @(negedge clk);
         if (eng_start === 1'b1) begin
            n_start++;
            if (lat_start < 0) begin
               lat_start = c; s_addr = eng_address; s_we = eng_write; s_din = eng_data_in; s_cs = cs_sel;
            end
         end
         if ((port ? ram_done : rom_done) === 1'b1) begin
            n_done++;
            if (lat_done < 0) begin
               lat_done = c - lat_start;
               if (port) ram_req = 1'b0;
               else rom_req = 1'b0;
            end
         end
      end
      rom_req = 1'b0;
      ram_req = 1'b0;
   endtask

   task automatic test_reset();
      logic [126:0] obs;
      int           busy_seen;
      @(negedge clk);
      obs = {eng_start, eng_write, eng_address, eng_data_in, cs_sel, active,
             rom_done, ram_done, rom_data, ram_rdata, timeout_err};
      checks++;
      if (obs !== 127'h0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
      end
      busy_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (eng_start !== 1'b0 || active !== 1'b0) busy_seen++;
      end
      checks++;
      if (busy_seen !== 0) begin
         errors++; $display("FAIL reset_idle_quiet: got %0d active cycles expected 0", busy_seen);
      end
   endtask

   task automatic test_rom_only();
      int ls, ld, ns, nd; logic [23:0] sa; logic sw, sc; logic [31:0] sd;
      eng_len = 8;
      run_txn(1'b0, 1'b0, 24'h000100, 32'h0, ls, ld, ns, nd, sa, sw, sd, sc);
      exp_rom_data = 32'hDEADBEEF;
      checks++; if (ls !== 1) begin errors++; $display("FAIL rom_start_latency: got %0d expected 1", ls); end
      checks++; if (sa !== 24'h800100) begin errors++; $display("FAIL rom_eng_address: got %h expected 800100", sa); end
      checks++; if (sw !== 1'b0) begin errors++; $display("FAIL rom_eng_write: got %b expected 0", sw); end
      checks++; if (sc !== 1'b0) begin errors++; $display("FAIL rom_cs_sel: got %b expected 0", sc); end
      checks++; if (nd !== 1 || ns !== 1) begin errors++; $display("FAIL rom_single_done: got %0d dones %0d starts expected 1 1", nd, ns); end
      checks++; if (ld !== eng_len + 2) begin errors++; $display("FAIL rom_done_latency: got %0d expected %0d", ld, eng_len + 2); end
      checks++; if (rom_data !== exp_rom_data) begin errors++; $display("FAIL rom_data: got %h expected %h", rom_data, exp_rom_data); end
   endtask

   task automatic test_ram_write_read();
      int ls, ld, ns, nd; logic [23:0] sa; logic sw, sc; logic [31:0] sd;
      eng_len = 5;
      run_txn(1'b1, 1'b1, 24'h12ABCD, 32'h0BADF00D, ls, ld, ns, nd, sa, sw, sd, sc);
      ref_ram[5'h0D] = 32'h0BADF00D;
      checks++; if (sw !== 1'b1 || sc !== 1'b1) begin errors++; $display("FAIL ramw_write_cs: got %b%b expected 11", sw, sc); end
      checks++; if (sd !== 32'h0BADF00D) begin errors++; $display("FAIL ramw_data_in: got %h expected 0badf00d", sd); end
      checks++; if (sa !== 24'h12ABCD) begin errors++; $display("FAIL ramw_address: got %h expected 12abcd", sa); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL ramw_done: got %0d expected 1", nd); end
      checks++; if (ram_rdata !== exp_ram_rdata) begin errors++; $display("FAIL ramw_rdata_held: got %h expected %h", ram_rdata, exp_ram_rdata); end
      run_txn(1'b1, 1'b0, 24'h12ABCD, 32'($urandom), ls, ld, ns, nd, sa, sw, sd, sc);
      exp_ram_rdata = ref_ram[5'h0D];
      checks++; if (sw !== 1'b0 || nd !== 1) begin errors++; $display("FAIL ramr_write_done: got %b %0d expected 0 1", sw, nd); end
      checks++; if (ram_rdata !== exp_ram_rdata) begin errors++; $display("FAIL ramr_rdata: got %h expected %h", ram_rdata, exp_ram_rdata); end
      checks++; if (rom_data !== exp_rom_data) begin errors++; $display("FAIL ramr_rom_held: got %h expected %h", rom_data, exp_rom_data); end
   endtask

   task automatic test_random();
      int ls, ld, ns, nd; logic [23:0] sa; logic sw, sc; logic [31:0] sd;
      bit port; logic we; logic [23:0] a, ea; logic [31:0] wd;
      for (int n = 0; n < 16; n++) begin
         port = 1'($urandom_range(0, 1));
         we   = port ? 1'($urandom_range(0, 1)) : 1'b0;
         a    = port ? 24'($urandom) : {1'b0, 23'($urandom)};
         wd   = 32'($urandom);
         eng_len = $urandom_range(1, 6);
         run_txn(port, we, a, wd, ls, ld, ns, nd, sa, sw, sd, sc);
         ea = port ? a : (24'h800000 | a);
         if (port && we) ref_ram[a[4:0]] = wd;
         else if (port) exp_ram_rdata = ref_ram[a[4:0]];
         else exp_rom_data = rom_word(ea);
         checks++; if (ls !== 1 || ns !== 1 || nd !== 1) begin errors++; $display("FAIL rnd_handshake[%0d]: got lat %0d starts %0d dones %0d expected 1 1 1", n, ls, ns, nd); end
         checks++; if ({sc, sw, sa} !== {port, we, ea}) begin errors++; $display("FAIL rnd_command[%0d]: got %h expected %h", n, {sc, sw, sa}, {port, we, ea}); end
         checks++; if (port && sd !== wd) begin errors++; $display("FAIL rnd_data_in[%0d]: got %h expected %h", n, sd, wd); end
         checks++; if (ld !== eng_len + 2) begin errors++; $display("FAIL rnd_done_latency[%0d]: got %0d expected %0d", n, ld, eng_len + 2); end
         checks++; if (rom_data !== exp_rom_data) begin errors++; $display("FAIL rnd_rom_data[%0d]: got %h expected %h", n, rom_data, exp_rom_data); end
         checks++; if (ram_rdata !== exp_ram_rdata) begin errors++; $display("FAIL rnd_ram_rdata[%0d]: got %h expected %h", n, ram_rdata, exp_ram_rdata); end
      end
   endtask

   task automatic test_contention();
      logic [22:0] ra; logic [23:0] wa; logic prev_cs;
      int starts, dones, idle_run;
      ra = 23'($urandom); wa = 24'($urandom);
      rom_addr = ra; ram_addr = wa; ram_we = 1'b0; ram_wdata = 32'h0;
      eng_len = $urandom_range(3, 6);
      do_reset(1'b1);
      starts = 0; dones = 0; idle_run = 0; prev_cs = 1'b0;
      for (int c = 0; c < 200 && dones < 4; c++) begin
         @(negedge clk);
         if (eng_start === 1'b1) begin
            checks++; if (cs_sel !== 1'(starts % 2)) begin errors++; $display("FAIL tie_grant_order[%0d]: got %b expected %b", starts, cs_sel, 1'(starts % 2)); end
            if (starts > 0) begin
               checks++; if (idle_run < CS_GAP) begin errors++; $display("FAIL tie_cs_gap[%0d]: got %0d expected >=%0d", starts, idle_run, CS_GAP); end
            end
            starts++;
         end else begin
            checks++; if (cs_sel !== prev_cs) begin errors++; $display("FAIL tie_cs_stable: got %b expected %b", cs_sel, prev_cs); end
         end
         if (active === 1'b0 && eng_start === 1'b0) idle_run++;
         else idle_run = 0;
         if (rom_done === 1'b1 || ram_done === 1'b1) begin
            checks++; if ({ram_done, rom_done} !== ((dones % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie_done_port[%0d]: got %b", dones, {ram_done, rom_done}); end
            checks++; if (rom_done === 1'b1 && rom_data !== rom_word(24'h800000 | 24'(ra))) begin errors++; $display("FAIL tie_rom_data: got %h expected %h", rom_data, rom_word(24'h800000 | 24'(ra))); end
            checks++; if (ram_done === 1'b1 && ram_rdata !== ref_ram[wa[4:0]]) begin errors++; $display("FAIL tie_ram_data: got %h expected %h", ram_rdata, ref_ram[wa[4:0]]); end
            dones++;
         end
         prev_cs = cs_sel;
      end
      rom_req = 1'b0; ram_req = 1'b0;
      exp_rom_data = rom_word(24'h800000 | 24'(ra));
      exp_ram_rdata = ref_ram[wa[4:0]];
      checks++; if (starts !== 4 || dones !== 4) begin errors++; $display("FAIL tie_count: got %0d starts %0d dones expected 4 4", starts, dones); end
   endtask

   task automatic test_drop_mid_xfer();
      logic [23:0] wa; int seen, nd, ns;
      wa = 24'($urandom); eng_len = $urandom_range(6, 10);
      repeat (CS_GAP + 2) @(negedge clk);
      ram_we = 1'b0; ram_addr = wa; ram_req = 1'b1;
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clk);
         if (eng_busy === 1'b1) seen = 1;
      end
      checks++; if (seen !== 1) begin errors++; $display("FAIL drop_busy_seen: got %0d expected 1", seen); end
      repeat (2) @(negedge clk);
      ram_req = 1'b0;
      nd = 0; ns = 0;
      for (int c = 0; c < TXN_BUDGET; c++) begin
         @(negedge clk);
         if (eng_start === 1'b1) ns++;
         if (ram_done === 1'b1) nd++;
      end
      exp_ram_rdata = ref_ram[wa[4:0]];
      checks++; if (nd !== 1) begin errors++; $display("FAIL drop_done_once: got %0d expected 1", nd); end
      checks++; if (ns !== 0) begin errors++; $display("FAIL drop_no_restart: got %0d expected 0", ns); end
      checks++; if (ram_rdata !== exp_ram_rdata) begin errors++; $display("FAIL drop_rdata: got %h expected %h", ram_rdata, exp_ram_rdata); end
   endtask

   task automatic test_timeout();
      int seen, ls, ld, ns, nd; logic [23:0] sa; logic sw, sc; logic [31:0] sd, wd; logic [23:0] wa;
      eng_stuck = 1'b1;
      repeat (CS_GAP + 2) @(negedge clk);
      rom_addr = 23'($urandom); rom_req = 1'b1;
      seen = 0;
      for (int c = 0; c < 5 && seen == 0; c++) begin
         @(negedge clk);
         if (eng_start === 1'b1) seen = 1;
      end
      checks++; if (seen !== 1) begin errors++; $display("FAIL to_start_seen: got %0d expected 1", seen); end
      for (int k = 1; k <= BUSY_TIMEOUT + 1; k++) begin
         @(negedge clk);
         if (k <= BUSY_TIMEOUT) begin
            checks++; if (timeout_err !== 1'b0 || rom_done !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got err %b done %b expected 0 0", k, timeout_err, rom_done); end
         end else begin
            checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b expected 1", timeout_err); end
            checks++; if (rom_done !== 1'b1) begin errors++; $display("FAIL to_rom_done: got %b expected 1", rom_done); end
            checks++; if (rom_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_rom_data: got %h expected ffffffff", rom_data); end
         end
      end
      rom_req = 1'b0; eng_stuck = 1'b0;
      exp_rom_data = 32'hFFFF_FFFF;
      wa = 24'($urandom); wd = 32'($urandom); eng_len = 3;
      run_txn(1'b1, 1'b1, wa, wd, ls, ld, ns, nd, sa, sw, sd, sc);
      ref_ram[wa[4:0]] = wd;
      checks++; if (ns !== 1 || nd !== 1) begin errors++; $display("FAIL to_next_served: got %0d starts %0d dones expected 1 1", ns, nd); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b expected 1", timeout_err); end
   endtask

   task automatic test_reset_mid_xfer();
      logic [126:0] obs; int seen, ls, ld, ns, nd, rd, wdn;
      logic [23:0] sa, wa; logic sw, sc; logic [31:0] sd;
      eng_len = 10;
      repeat (CS_GAP + 2) @(negedge clk);
      ram_we = 1'b1; ram_addr = 24'($urandom); ram_wdata = 32'($urandom); ram_req = 1'b1;
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clk);
         if (eng_busy === 1'b1) seen = 1;
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      obs = {eng_start, eng_write, eng_address, eng_data_in, cs_sel, active,
             rom_done, ram_done, rom_data, ram_rdata, timeout_err};
      checks++; if (seen !== 1 || obs !== 127'h0) begin errors++; $display("FAIL rst_async_outputs: got busy_seen %0d outputs %h expected 1 0", seen, obs); end
      ram_req = 1'b0;
      for (int i = 0; i < 32; i++) ref_ram[i] = ram_init(i);
      @(negedge clk);
      rst_n = 1'b1;
      wa = 24'($urandom);
      run_txn(1'b1, 1'b0, wa, 32'h0, ls, ld, ns, nd, sa, sw, sd, sc);
      checks++; if (nd !== 1 || ram_rdata !== ref_ram[wa[4:0]]) begin errors++; $display("FAIL rst_ram_read: got %0d %h expected 1 %h", nd, ram_rdata, ref_ram[wa[4:0]]); end
      repeat (CS_GAP + 2) @(negedge clk);
      rom_addr = 23'($urandom); ram_addr = wa; ram_we = 1'b0; rom_req = 1'b1; ram_req = 1'b1;
      @(negedge clk);
      checks++; if (eng_start !== 1'b1 || cs_sel !== 1'b0) begin errors++; $display("FAIL rst_tie_rom_first: got start %b cs %b expected 1 0", eng_start, cs_sel); end
      rd = 0; wdn = 0;
      for (int c = 0; c < 80 && (rd == 0 || wdn == 0); c++) begin
         @(negedge clk);
         if (rom_done === 1'b1) begin rd++; rom_req = 1'b0; end
         if (ram_done === 1'b1) begin wdn++; ram_req = 1'b0; end
      end
      rom_req = 1'b0; ram_req = 1'b0;
      checks++; if (rd !== 1 || wdn !== 1) begin errors++; $display("FAIL rst_tie_both_served: got %0d %0d expected 1 1", rd, wdn); end
   endtask

   initial begin
      rst_n = 1'b0; rom_req = 1'b0; ram_req = 1'b0; ram_we = 1'b0;
      rom_addr = 23'h0; ram_addr = 24'h0; ram_wdata = 32'h0;
      do_reset(1'b0);
      test_reset();
      test_rom_only();
      test_ram_write_read();
      test_random();
      test_contention();
      test_drop_mid_xfer();
      test_timeout();
      test_reset_mid_xfer();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/qspi_arbiter.md
Name: qspi_arbiter

Overview:
- Shares the single QSPI engine (one SCLK/IO set, separate chip selects) between two requesters: the instruction-fetch port (ROM, read-only) and the data port (RAM, read/write).
- Accepts a request from each port, arbitrates between them, sequences one engine transaction at a time, and selects the chip select.
- Enforces a minimum CS-high gap between transactions and returns read data with a done pulse to the granted port.

Parameters:
- CS_GAP, 2: idle cycles between the end of one transaction and the next eng_start; must be ≥1.
- BUSY_TIMEOUT, 16: cycles allowed from eng_start until eng_busy rises before the transaction is aborted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rom_req  in  1  fetch request; held with rom_addr stable until rom_done
- rom_addr  in  23  fetch word address
- rom_data  out  32  last fetch result
- rom_done  out  1  one-cycle completion pulse
- ram_req  in  1  data request; held with ram_we/ram_addr/ram_wdata stable until ram_done
- ram_we  in  1  1 = write, 0 = read
- ram_addr  in  24  RAM address {mpage, mar}
- ram_wdata  in  32  write data
- ram_rdata  out  32  last RAM read result
- ram_done  out  1  one-cycle completion pulse
- eng_start  out  1  one-cycle start to the QSPI engine
- eng_write  out  1  engine write select
- eng_address  out  24  engine address
- eng_data_in  out  32  engine write data
- eng_data_out  in  32  engine read data, valid when eng_busy falls
- eng_busy  in  1  engine busy
- cs_sel  out  1  chip-select mux: 0 = ROM (flash), 1 = RAM
- active  out  1  high from ISSUE through DONE
- timeout_err  out  1  sticky error flag

Behaviour:
- All outputs are registered.
- Reset values: eng_start 0, eng_write 0, eng_address 0, eng_data_in 0, cs_sel 0, active 0, rom_done 0, ram_done 0, rom_data 0, ram_rdata 0, timeout_err 0, state IDLE, last_grant RAM.
- Reset is asynchronous and takes effect mid-transaction: all state and outputs return to reset values immediately. The engine shares the same reset.

States:
- IDLE: sample requests.
  - Both requests high: grant the port not served last (last_grant), so ROM goes first after reset.
  - One request high: grant that port.
  - No request: stay in IDLE.
  - On grant: latch port, write (ROM forces 0), address, and write data; go to ISSUE.
- ISSUE (1 cycle): eng_start=1, cs_sel=grant, active=1; then WAIT_BUSY.
- WAIT_BUSY: count cycles.
  - eng_busy=1 goes to XFER.
  - Count reaching BUSY_TIMEOUT with busy still low: set timeout_err, load 32'hFFFF_FFFF into the granted port's data register, go to DONE.
- XFER: wait for eng_busy=0; then capture eng_data_out into rom_data or ram_rdata (RAM writes leave ram_rdata unchanged); go to DONE.
- DONE (1 cycle): pulse the granted port's done, update last_grant, go to GAP.
- GAP: active=0, CS_GAP cycles; then IDLE.

Address and data rules:
- ROM: eng_address = {1'b1, rom_addr}, eng_write = 0.
- RAM: eng_address = ram_addr, eng_write = ram_we, eng_data_in = ram_wdata.
- eng_address, eng_write, eng_data_in and cs_sel change only on the IDLE→ISSUE transition. They are stable from ISSUE through GAP.

Latency:
- A request seen in IDLE at edge N gives eng_start high in cycle N+1.
- done pulses in the cycle after the falling edge of eng_busy is sampled.
- Data registers update in the same cycle as done and hold until that port's next completion.

Handshake:
- A requester wanting a single transaction drops req in the cycle done is high.
- Because GAP is ≥1 cycle, no duplicate transaction is issued.
- req dropping mid-transaction is ignored: the transaction completes and done still pulses.
- A request changing its address while pending is not supported.

Fairness:
- Under continuous requests from both ports, grants strictly alternate.
- A lone requester is served back-to-back, separated only by GAP.

timeout_err:
- Cleared only by reset.
- Does not block further transactions.

Test Plan:
- ROM only: rom_req, rom_addr=23'h000100; engine model busy 8 cycles, returns 32'hDEADBEEF.
  - Expect eng_start one cycle after req, eng_address=24'h800100, eng_write=0, cs_sel=0.
  - Expect a single rom_done pulse with rom_data=32'hDEADBEEF.
- RAM write then read: ram_we=1, ram_addr=24'h12ABCD, ram_wdata=32'h0BADF00D.
  - Expect eng_write=1, eng_data_in=32'h0BADF00D, cs_sel=1, ram_done, ram_rdata unchanged.
  - Then a read at the same address, with the model returning 32'h0BADF00D, updates ram_rdata.
- Contention: both req high from reset and held.
  - Expect grant order ROM, RAM, ROM, RAM.
  - Expect ≥CS_GAP cycles of eng_start=0/active=0 between transactions.
  - Expect cs_sel to change only between transactions.
- Requester drops req two cycles into XFER.
  - Expect the transaction to complete and done to pulse once.
  - Expect no new start for that port.
- eng_busy stuck low.
  - Expect timeout_err=1 after BUSY_TIMEOUT=16 cycles, rom_done pulses, rom_data=32'hFFFF_FFFF.
  - Expect the next request to still be served.
- rst_n asserted mid-XFER.
  - Expect all outputs at reset values immediately, without waiting for a clock.
  - After release, a new RAM read completes normally with last_grant=RAM, so ROM wins the first tie.
